lookup_req_arbiter: RTL and testbench
=====================================

# lookup_req_arbiter

Shares one OpenFlow lookup engine among NUM_REQ header sources, such as per-port header parsers and a software-injected lookup path. Round-robin arbitration picks one requester. The block captures that requester's header bus, drives one lookup transaction, and routes the hit/miss result back to the granted requester. It sits between the header parsers and the exact/wildcard match tables.

## Interface
Parameters:
- NUM_REQ, 2: number of requesters, 2..8.
- HDR_WIDTH, `OF_HEADER_REG_WIDTH: width of one header bus.
- RES_WIDTH, 32: width of the lookup result (action pointer).
- TIMEOUT, 255: maximum cycles spent waiting for lkp_done; 0 disables the timeout.

Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-low (0 = reset).
- req_valid  in  NUM_REQ  per-requester request; held high with a stable header until req_ack.
- req_hdr  in  NUM_REQ*HDR_WIDTH  flattened header buses; slice i is [i*HDR_WIDTH +: HDR_WIDTH].
- req_ack  out  NUM_REQ  one-hot, one-cycle pulse; the header is captured.
- rsp_valid  out  NUM_REQ  one-hot, one-cycle pulse to the granted requester.
- rsp_hit  out  1  lookup hit; valid with rsp_valid.
- rsp_timeout  out  1  engine did not answer; forces rsp_hit=0.
- rsp_data  out  RES_WIDTH  lookup result; 0 on miss or timeout.
- lkp_req  out  1  lookup request to the engine.
- lkp_hdr  out  HDR_WIDTH  captured header, stable from grant until return to IDLE.
- lkp_rdy  in  1  engine accepts when lkp_req && lkp_rdy.
- lkp_done  in  1  one-cycle completion strobe.
- lkp_hit  in  1  hit flag, valid with lkp_done.
- lkp_data  in  RES_WIDTH  result, valid with lkp_done.
- busy  out  1  state != IDLE.

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any req_valid is set, pick the first set bit searching upward from ptr with wrap. Register the grant index g, capture hdr slice g into lkp_hdr, pulse req_ack[g], then go to ISSUE.
- ISSUE: lkp_req=1. On lkp_rdy go to WAIT and clear the timeout counter. A lkp_done seen in ISSUE is ignored.
- WAIT: lkp_req=0 and the counter increments.
  - On lkp_done, latch lkp_hit/lkp_data and go to RESP.
  - Otherwise, if TIMEOUT!=0 and the counter reaches TIMEOUT, latch hit=0, data=0, timeout=1 and go to RESP.
  - If lkp_done and expiry occur in the same cycle, lkp_done wins.
- RESP: pulse rsp_valid[g] with the latched rsp_* values. Set ptr=(g+1) mod NUM_REQ, go to IDLE.
- Counter width is clog2(TIMEOUT+1), saturating. ptr width is clog2(NUM_REQ); the wrap is explicit because NUM_REQ need not be a power of 2.
- Requests arriving while busy wait; req_valid is level-sensitive, so nothing is lost.
- Reset mid-transaction: the transaction is abandoned and no rsp_valid is issued. Requesters and the engine are reset by the same signal.

## Timing
- Reset values: state=IDLE, ptr=0, req_ack=0, rsp_valid=0, rsp_hit=0, rsp_timeout=0, rsp_data=0, lkp_req=0, lkp_hdr=0, busy=0.
- All outputs are registered.
- req_valid seen high in cycle 0 (IDLE) gives req_ack and lkp_req high in cycle 1.
- With lkp_rdy=1, acceptance happens in cycle 1 and WAIT starts in cycle 2.
- lkp_done in cycle n gives rsp_valid in cycle n+1, then IDLE in cycle n+2.
- Minimum request-to-request spacing is 4 cycles: sustained throughput is one lookup per 4 cycles plus engine latency.
- Timeout response: rsp_valid appears TIMEOUT+1 cycles after the cycle that starts WAIT.

## Configuration
- LKP_ARB_STATS_EN defined: adds outputs stat_grants (32 bits, count of grants) and stat_timeouts (32 bits, count of timeout responses). Both reset to 0, wrap at 2^32, and increment in the req_ack and timeout-RESP cycles respectively.
- LKP_ARB_STATS_EN undefined: the ports and counters are absent and there is no other behavioural difference.

## Structure
- Shared defines/package: state encoding (LKP_ARB_IDLE..LKP_ARB_RESP) and the clog2 function, reused by other table controllers.
- One sub-module, lkp_rr_pick: purely combinational. Inputs are req_valid and ptr; outputs are any and idx. It is kept separate so it can be unit-tested.
- The FSM, capture registers, timeout counter and stats live in lookup_req_arbiter.

## Test plan
- Single request: req_valid=01, hdr0=0xA5.., lkp_rdy=1, lkp_done 3 cycles after accept with hit=1, data=0x12 → req_ack=01 in cycle 1; rsp_valid=01 with rsp_hit=1, rsp_data=0x12.
- Fairness: req_valid=11 held constantly with NUM_REQ=2 → grants alternate 0,1,0,1 over 4 transactions; ptr wraps correctly.
- Backpressure: lkp_rdy=0 for 10 cycles → lkp_req stays high and lkp_hdr stable; a spurious lkp_done during ISSUE is ignored.
- Timeout: TIMEOUT=8, no lkp_done → rsp_valid 9 cycles after WAIT entry with rsp_timeout=1, rsp_hit=0, rsp_data=0.
- Same-cycle done/expiry with hit=1, data=0x7 → rsp_hit=1, rsp_timeout=0.
- Async reset asserted during WAIT → all outputs 0 immediately; no rsp_valid follows; the next request is granted from ptr=0.

Source files
------------

// File: rtl/lookup_req_arbiter_pkg.sv
// Shared lookup-arbiter types: FSM state encoding and a width helper reused by table controllers.
// Also supplies a default header-bus width for builds that do not define OF_HEADER_REG_WIDTH.
`ifndef OF_HEADER_REG_WIDTH
`define OF_HEADER_REG_WIDTH 64
`endif

package lookup_req_arbiter_pkg;

  typedef enum logic [1:0] {
    LKP_ARB_IDLE  = 2'd0,
    LKP_ARB_ISSUE = 2'd1,
    LKP_ARB_WAIT  = 2'd2,
    LKP_ARB_RESP  = 2'd3
  } lkp_arb_state_t;

  // Ceiling log2, clamped to 1 so a counter or index never collapses to zero width.
  function automatic int lkp_clog2(input int value);
    int width;
    width = 0;
    while ((1 << width) < value) width++;
    return (width < 1) ? 1 : width;
  endfunction

endpackage

// File: rtl/lookup_req_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping past NUM_REQ-1.
// Zero latency; idx is only meaningful while any is high.
module lkp_rr_pick
  import lookup_req_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int PW      = lkp_clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [PW-1:0]      ptr,
  output logic               any,
  output logic [PW-1:0]      idx
);

  logic [PW:0] w_pos;

  // Walk from the farthest candidate back to ptr so the closest set bit is written last.
  always_comb begin
    idx   = '0;
    w_pos = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      w_pos = {1'b0, ptr} + (PW+1)'(i);
      if (w_pos >= (PW+1)'(NUM_REQ)) w_pos = w_pos - (PW+1)'(NUM_REQ);
      if (req_valid[w_pos[PW-1:0]]) idx = w_pos[PW-1:0];
    end
  end

  assign any = |req_valid;

endmodule

// File: rtl/lookup_req_arbiter.sv
// Round-robin share of one lookup engine: grant -> ack+lkp_req next cycle, rsp one cycle after lkp_done.
// Engine stalls hold lkp_req/lkp_hdr; waiting requesters stay pending. LKP_ARB_STATS_EN adds grant/timeout counters.
module lookup_req_arbiter
  import lookup_req_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int HDR_WIDTH = `OF_HEADER_REG_WIDTH,
  parameter int RES_WIDTH = 32,
  parameter int TIMEOUT   = 255
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*HDR_WIDTH-1:0] req_hdr,
  output logic [NUM_REQ-1:0]           req_ack,
  output logic [NUM_REQ-1:0]           rsp_valid,
  output logic                         rsp_hit,
  output logic                         rsp_timeout,
  output logic [RES_WIDTH-1:0]         rsp_data,
  output logic                         lkp_req,
  output logic [HDR_WIDTH-1:0]         lkp_hdr,
  input  logic                         lkp_rdy,
  input  logic                         lkp_done,
  input  logic                         lkp_hit,
  input  logic [RES_WIDTH-1:0]         lkp_data,
`ifdef LKP_ARB_STATS_EN
  output logic [31:0]                  stat_grants,
  output logic [31:0]                  stat_timeouts,
`endif
  output logic                         busy
);

  localparam int PW = lkp_clog2(NUM_REQ);
  localparam int CW = lkp_clog2(TIMEOUT + 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

  lkp_arb_state_t r_state, w_state_nxt;

  logic [PW-1:0]        r_ptr;
  logic [PW-1:0]        r_gnt;
  logic [CW-1:0]        r_cnt;
  logic [NUM_REQ-1:0]   r_req_ack;
  logic [NUM_REQ-1:0]   r_rsp_valid;
  logic                 r_rsp_hit;
  logic                 r_rsp_timeout;
  logic [RES_WIDTH-1:0] r_rsp_data;
  logic                 r_lkp_req;
  logic [HDR_WIDTH-1:0] r_lkp_hdr;
  logic                 r_busy;

  logic          w_any;
  logic [PW-1:0] w_idx;
  logic          w_grant;
  logic          w_expire;
  logic          w_done;
  logic          w_tmo;

  lkp_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PW      (PW)
  ) u_pick (
    .req_valid (req_valid),
    .ptr       (r_ptr),
    .any       (w_any),
    .idx       (w_idx)
  );

  assign w_grant  = (r_state == LKP_ARB_IDLE) && w_any;
  assign w_expire = (TIMEOUT != 0) && (r_cnt == CW'(TIMEOUT));
  assign w_done   = (r_state == LKP_ARB_WAIT) && lkp_done;
  // A completion arriving on the expiry cycle still counts as a real answer.
  assign w_tmo    = (r_state == LKP_ARB_WAIT) && !lkp_done && w_expire;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= LKP_ARB_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      LKP_ARB_IDLE:  if (w_any) w_state_nxt = LKP_ARB_ISSUE;
      LKP_ARB_ISSUE: if (lkp_rdy) w_state_nxt = LKP_ARB_WAIT;
      LKP_ARB_WAIT:  if (lkp_done || w_expire) w_state_nxt = LKP_ARB_RESP;
      LKP_ARB_RESP:  w_state_nxt = LKP_ARB_IDLE;
      default:       w_state_nxt = LKP_ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ptr         <= '0;
      r_gnt         <= '0;
      r_cnt         <= '0;
      r_req_ack     <= '0;
      r_rsp_valid   <= '0;
      r_rsp_hit     <= 1'b0;
      r_rsp_timeout <= 1'b0;
      r_rsp_data    <= '0;
      r_lkp_req     <= 1'b0;
      r_lkp_hdr     <= '0;
      r_busy        <= 1'b0;
    end else begin
      r_req_ack   <= '0;
      r_rsp_valid <= '0;
      r_lkp_req   <= (w_state_nxt == LKP_ARB_ISSUE);
      r_busy      <= (w_state_nxt != LKP_ARB_IDLE);
      if (w_grant) begin
        r_gnt     <= w_idx;
        r_lkp_hdr <= req_hdr[w_idx*HDR_WIDTH +: HDR_WIDTH];
        r_req_ack <= ONE_HOT0 << w_idx;
      end
      if ((r_state == LKP_ARB_ISSUE) && lkp_rdy) r_cnt <= '0;
      if ((r_state == LKP_ARB_WAIT) && (r_cnt != '1)) r_cnt <= r_cnt + 1'b1;
      if (w_done) begin
        r_rsp_valid   <= ONE_HOT0 << r_gnt;
        r_rsp_hit     <= lkp_hit;
        r_rsp_timeout <= 1'b0;
        r_rsp_data    <= lkp_hit ? lkp_data : '0;
      end else if (w_tmo) begin
        r_rsp_valid   <= ONE_HOT0 << r_gnt;
        r_rsp_hit     <= 1'b0;
        r_rsp_timeout <= 1'b1;
        r_rsp_data    <= '0;
      end
      if (r_state == LKP_ARB_RESP)
        r_ptr <= (r_gnt == PW'(NUM_REQ - 1)) ? '0 : r_gnt + 1'b1;
    end
  end

  assign req_ack     = r_req_ack;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_hit     = r_rsp_hit;
  assign rsp_timeout = r_rsp_timeout;
  assign rsp_data    = r_rsp_data;
  assign lkp_req     = r_lkp_req;
  assign lkp_hdr     = r_lkp_hdr;
  assign busy        = r_busy;

`ifdef LKP_ARB_STATS_EN
  logic [31:0] r_stat_grants;
  logic [31:0] r_stat_timeouts;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stat_grants   <= '0;
      r_stat_timeouts <= '0;
    end else begin
      if (w_grant) r_stat_grants <= r_stat_grants + 32'd1;
      if (w_tmo)   r_stat_timeouts <= r_stat_timeouts + 32'd1;
    end
  end

  assign stat_grants   = r_stat_grants;
  assign stat_timeouts = r_stat_timeouts;
`endif

endmodule

// File: tb/tb_lookup_req_arbiter.sv
// Scoreboarded bench for lookup_req_arbiter: two requesters, 64-bit headers, TIMEOUT=8.
module tb_lookup_req_arbiter;

  localparam int NUM_REQ   = 2;
  localparam int HDR_WIDTH = 64;
  localparam int RES_WIDTH = 32;
  localparam int TIMEOUT   = 8;

  typedef struct packed {
    logic [1:0]  vld;
    logic        hit;
    logic        tmo;
    logic [31:0] data;
  } exp_t;

  logic                         clk;
  logic                         reset;
  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ*HDR_WIDTH-1:0] req_hdr;
  logic [NUM_REQ-1:0]           req_ack;
  logic [NUM_REQ-1:0]           rsp_valid;
  logic                         rsp_hit;
  logic                         rsp_timeout;
  logic [RES_WIDTH-1:0]         rsp_data;
  logic                         lkp_req;
  logic [HDR_WIDTH-1:0]         lkp_hdr;
  logic                         lkp_rdy;
  logic                         lkp_done;
  logic                         lkp_hit;
  logic [RES_WIDTH-1:0]         lkp_data;
  logic                         busy;

  int   n_chk;
  int   n_pass;
  exp_t sb_q[$];

  lookup_req_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .HDR_WIDTH (HDR_WIDTH),
    .RES_WIDTH (RES_WIDTH),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_hdr     (req_hdr),
    .req_ack     (req_ack),
    .rsp_valid   (rsp_valid),
    .rsp_hit     (rsp_hit),
    .rsp_timeout (rsp_timeout),
    .rsp_data    (rsp_data),
    .lkp_req     (lkp_req),
    .lkp_hdr     (lkp_hdr),
    .lkp_rdy     (lkp_rdy),
    .lkp_done    (lkp_done),
    .lkp_hit     (lkp_hit),
    .lkp_data    (lkp_data),
    .busy        (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Response monitor: every rsp_valid pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    exp_t e;
    if (reset && (rsp_valid != '0)) begin
      if (sb_q.size() == 0) begin
        check_eq("rsp_unexpected", 64'(rsp_valid), 64'd0);
      end else begin
        e = sb_q.pop_front();
        check_eq("rsp_valid", 64'(rsp_valid), 64'(e.vld));
        check_eq("rsp_hit", 64'(rsp_hit), 64'(e.hit));
        check_eq("rsp_timeout", 64'(rsp_timeout), 64'(e.tmo));
        check_eq("rsp_data", 64'(rsp_data), 64'(e.data));
      end
    end
  end

  function automatic logic [63:0] hdr_of(input logic [1:0] gnt);
    return gnt[1] ? req_hdr[127:64] : req_hdr[63:0];
  endfunction

  // One full transaction with the engine ready; lkp_done arrives dly cycles after the accept cycle.
  task automatic run_txn(input string tag, input logic [1:0] req, input logic [1:0] exp_gnt,
                         input bit hold, input int dly, input logic hit, input logic [31:0] data);
    int n;
    req_hdr   = {$urandom, $urandom, $urandom, $urandom};
    req_valid = req;
    lkp_rdy   = 1'b1;
    sb_q.push_back('{vld: exp_gnt, hit: hit, tmo: 1'b0, data: (hit ? data : 32'h0)});
    n = 0;
    do begin tick(); n++; end while ((req_ack == '0) && (n < 20));
    check_eq({tag, "_ack"}, 64'(req_ack), 64'(exp_gnt));
    check_eq({tag, "_ack_lat"}, 64'(n), 64'd1);
    check_eq({tag, "_lkp_req"}, 64'(lkp_req), 64'd1);
    check_eq({tag, "_lkp_hdr"}, lkp_hdr, hdr_of(exp_gnt));
    if (!hold) req_valid = req & ~exp_gnt;
    repeat (dly) tick();
    lkp_done = 1'b1;
    lkp_hit  = hit;
    lkp_data = data;
    tick();
    lkp_done = 1'b0;
    lkp_hit  = 1'b0;
    lkp_data = '0;
    check_eq({tag, "_rsp_cycle"}, 64'(rsp_valid), 64'(exp_gnt));
    tick();
    check_eq({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int n;
    n_chk     = 0;
    n_pass    = 0;
    reset     = 1'b1;
    req_valid = '0;
    req_hdr   = '0;
    lkp_rdy   = 1'b0;
    lkp_done  = 1'b0;
    lkp_hit   = 1'b0;
    lkp_data  = '0;
    #2 reset = 1'b0;
    #2;
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_req_ack", 64'(req_ack), 64'd0);
    check_eq("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check_eq("rst_lkp_req", 64'(lkp_req), 64'd0);
    check_eq("rst_lkp_hdr", lkp_hdr, 64'd0);
    check_eq("rst_rsp_data", 64'(rsp_data), 64'd0);
    repeat (2) tick();
    reset = 1'b1;
    tick();

    run_txn("single", 2'b01, 2'b01, 1'b0, 3, 1'b1, 32'h12);
    run_txn("wrap_low", 2'b01, 2'b01, 1'b0, 2, 1'b0, 32'h55);
    run_txn("req1", 2'b10, 2'b10, 1'b0, 1, 1'b1, 32'hABC);
    run_txn("fair0", 2'b11, 2'b01, 1'b1, 2, 1'b1, 32'h100);
    run_txn("fair1", 2'b11, 2'b10, 1'b1, 2, 1'b1, 32'h101);
    run_txn("fair2", 2'b11, 2'b01, 1'b1, 2, 1'b1, 32'h102);
    run_txn("fair3", 2'b11, 2'b10, 1'b0, 2, 1'b1, 32'h103);

    // Engine stalls for 10 cycles with a stray done strobe; the captured header must not move.
    req_hdr   = {64'h1111_2222_3333_4444, 64'hA5A5_A5A5_0000_00BB};
    req_valid = 2'b01;
    lkp_rdy   = 1'b0;
    sb_q.push_back('{vld: 2'b01, hit: 1'b1, tmo: 1'b0, data: 32'h33});
    tick();
    check_eq("bp_ack", 64'(req_ack), 64'd1);
    req_valid = '0;
    req_hdr   = '1;
    for (int i = 0; i < 10; i++) begin
      check_eq("bp_lkp_req", 64'(lkp_req), 64'd1);
      check_eq("bp_lkp_hdr", lkp_hdr, 64'hA5A5_A5A5_0000_00BB);
      check_eq("bp_no_rsp", 64'(rsp_valid), 64'd0);
      lkp_done = (i == 4);
      lkp_hit  = 1'b1;
      lkp_data = 32'hDEAD;
      tick();
    end
    lkp_done = 1'b0;
    lkp_rdy  = 1'b1;
    tick();
    lkp_rdy  = 1'b0;
    check_eq("bp_wait_lkp_req", 64'(lkp_req), 64'd0);
    check_eq("bp_wait_hdr", lkp_hdr, 64'hA5A5_A5A5_0000_00BB);
    lkp_done = 1'b1;
    lkp_data = 32'h33;
    tick();
    lkp_done = 1'b0;
    lkp_hit  = 1'b0;
    lkp_data = '0;
    check_eq("bp_rsp_cycle", 64'(rsp_valid), 64'd1);
    tick();

    // No answer at all: response must follow WAIT entry by TIMEOUT+1 cycles with forced zeros.
    req_hdr   = {$urandom, $urandom, $urandom, $urandom};
    req_valid = 2'b10;
    lkp_rdy   = 1'b1;
    lkp_hit   = 1'b1;
    lkp_data  = 32'hFFFF_FFFF;
    sb_q.push_back('{vld: 2'b10, hit: 1'b0, tmo: 1'b1, data: 32'h0});
    tick();
    check_eq("tmo_ack", 64'(req_ack), 64'd2);
    req_valid = '0;
    n = 0;
    do begin tick(); n++; end while ((rsp_valid == '0) && (n < 40));
    check_eq("tmo_latency", 64'(n), 64'(TIMEOUT + 2));
    lkp_hit  = 1'b0;
    lkp_data = '0;
    tick();

    run_txn("done_vs_expiry", 2'b01, 2'b01, 1'b0, TIMEOUT + 1, 1'b1, 32'h7);

    // Reset lands during WAIT of a grant to requester 1; the pointer must come back at 0.
    req_valid = 2'b10;
    lkp_rdy   = 1'b1;
    tick();
    check_eq("rstw_ack", 64'(req_ack), 64'd2);
    req_valid = '0;
    repeat (2) tick();
    check_eq("rstw_busy_before", 64'(busy), 64'd1);
    #2 reset = 1'b0;
    #1;
    check_eq("rstw_busy", 64'(busy), 64'd0);
    check_eq("rstw_lkp_req", 64'(lkp_req), 64'd0);
    check_eq("rstw_lkp_hdr", lkp_hdr, 64'd0);
    check_eq("rstw_rsp_valid", 64'(rsp_valid), 64'd0);
    check_eq("rstw_req_ack", 64'(req_ack), 64'd0);
    repeat (2) tick();
    reset = 1'b1;
    repeat (12) tick();
    run_txn("after_reset", 2'b11, 2'b01, 1'b0, 2, 1'b1, 32'h99);

    repeat (3) tick();
    check_eq("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
